// File: rtl/me_pkg.sv
// Shared types and byte-enable helpers for the memory-stage load/store unit.
package me_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_len_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } me_state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Encoding 2'b11 is not a distinct size; it behaves as a word access.
  function automatic mem_len_e norm_len(input logic [1:0] len);
    return (len == 2'b11) ? WORD : mem_len_e'(len);
  endfunction

  function automatic logic [3:0] byte_en(input mem_len_e len, input logic [1:0] off);
    case (len)
      BYTE:    return BE_BYTE << off;
      HALF:    return BE_HALF << {off[1], 1'b0};
      default: return BE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/me_load_align.sv
// Combinational load extractor: shifts the bus word down to the accessed lane and extends it.
module me_load_align
  import me_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_offset,
  input  mem_len_e    i_len,
  input  logic        i_sign,
  output logic [31:0] o_load_data
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_offset, 3'b000};

  always_comb begin
    o_load_data = w_shifted;
    case (i_len)
      BYTE:    o_load_data = {{24{i_sign & w_shifted[7]}}, w_shifted[7:0]};
      HALF:    o_load_data = {{16{i_sign & w_shifted[15]}}, w_shifted[15:0]};
      default: o_load_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/me_mem_access.sv
// Memory-stage load/store unit driving a req/gnt/rvalid bus; stalls the pipeline until DONE.
// Optional MEM_MISALIGN_TRAP_EN: misaligned accesses skip the bus and flag misalign instead of aligning.
module me_mem_access
  import me_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_read_in,
  input  logic            mem_write_en_in,
  input  logic            mem_sign_in,
  input  logic [1:0]      mem_length_in,
  input  logic [XLEN-1:0] addr_in,
  input  logic [XLEN-1:0] write_data_in,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            stall,
  output logic [XLEN-1:0] load_data,
  output logic            load_valid
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic            misalign
`endif
);

  me_state_e   r_state;
  logic [1:0]  r_off;
  mem_len_e    r_len;
  logic        r_sign;
  logic        r_is_load;

  logic        w_access;
  mem_len_e    w_len;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;

  assign w_access = mem_read_in | mem_write_en_in;
  assign w_len    = norm_len(mem_length_in);
  assign w_be     = byte_en(w_len, w_off);
  assign stall    = ((r_state == IDLE) && w_access) || (r_state == REQ) || (r_state == RESP);

`ifdef MEM_MISALIGN_TRAP_EN
  logic w_misalign;
  assign w_misalign = ((w_len == HALF) && addr_in[0]) ||
                      ((w_len == WORD) && (addr_in[1:0] != 2'b00));
`endif

  // Offset bits below the access size are dropped, which silently aligns the access.
  always_comb begin
    w_off   = 2'b00;
    w_wdata = write_data_in;
    case (w_len)
      BYTE: begin
        w_off   = addr_in[1:0];
        w_wdata = {4{write_data_in[7:0]}};
      end
      HALF: begin
        w_off   = {addr_in[1], 1'b0};
        w_wdata = {2{write_data_in[15:0]}};
      end
      default: begin
        w_off   = 2'b00;
        w_wdata = write_data_in;
      end
    endcase
  end

  me_load_align u_load_align (
    .i_rdata     (dmem_rdata),
    .i_offset    (r_off),
    .i_len       (r_len),
    .i_sign      (r_sign),
    .o_load_data (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_off      <= 2'b00;
      r_len      <= BYTE;
      r_sign     <= 1'b0;
      r_is_load  <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= 4'b0000;
      dmem_wdata <= '0;
      load_data  <= '0;
      load_valid <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          load_valid <= 1'b0;
          if (w_access) begin
            r_off     <= w_off;
            r_len     <= w_len;
            r_sign    <= mem_sign_in;
            r_is_load <= ~mem_write_en_in;
`ifdef MEM_MISALIGN_TRAP_EN
            if (w_misalign) begin
              misalign  <= 1'b1;
              load_data <= '0;
              r_state   <= DONE;
            end else
`endif
            begin
              dmem_req   <= 1'b1;
              dmem_we    <= mem_write_en_in;
              dmem_addr  <= {addr_in[XLEN-1:2], 2'b00};
              dmem_be    <= w_be;
              dmem_wdata <= w_wdata;
              r_state    <= REQ;
            end
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            r_state  <= r_is_load ? RESP : DONE;
          end
        end
        RESP: begin
          if (dmem_rvalid) begin
            load_data  <= w_load_data;
            load_valid <= 1'b1;
            r_state    <= DONE;
          end
        end
        default: begin
          load_valid <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
          misalign   <= 1'b0;
`endif
          r_state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_me_mem_access.sv
// Directed bench for me_mem_access: bus responder per step, load results checked from a scoreboard queue.
module tb_me_mem_access;

  logic        clk;
  logic        rst;
  logic        mem_read_in;
  logic        mem_write_en_in;
  logic        mem_sign_in;
  logic [1:0]  mem_length_in;
  logic [31:0] addr_in;
  logic [31:0] write_data_in;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int errors = 0;
  int checks = 0;
  int lv_count = 0;
  int n_loads = 0;
  logic [31:0] exp_q[$];

  me_mem_access #(.XLEN(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read_in     (mem_read_in),
    .mem_write_en_in (mem_write_en_in),
    .mem_sign_in     (mem_sign_in),
    .mem_length_in   (mem_length_in),
    .addr_in         (addr_in),
    .write_data_in   (write_data_in),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_be         (dmem_be),
    .dmem_wdata      (dmem_wdata),
    .dmem_gnt        (dmem_gnt),
    .dmem_rvalid     (dmem_rvalid),
    .dmem_rdata      (dmem_rdata),
    .stall           (stall),
    .load_data       (load_data),
    .load_valid      (load_valid)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .misalign        (misalign)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every load_valid pulse must match the oldest queued load.
  always @(negedge clk) begin
    if (load_valid === 1'b1) begin
      lv_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_load_valid", 32'd1, 32'd0);
      end else begin
        check("load_data", load_data, exp_q.pop_front());
      end
    end
  end

  task automatic clear_inputs();
    mem_read_in     = 1'b0;
    mem_write_en_in = 1'b0;
    mem_sign_in     = 1'b0;
    mem_length_in   = 2'b00;
    addr_in         = '0;
    write_data_in   = '0;
  endtask

  // Runs one access starting at a negedge in IDLE and ends at a negedge back in IDLE.
  task automatic access(input logic rd, input logic wr, input logic sgn, input logic [1:0] len,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                        input int gnt_dly, input int rv_dly,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_ld);
    logic is_load;
    is_load         = rd & ~wr;
    mem_read_in     = rd;
    mem_write_en_in = wr;
    mem_sign_in     = sgn;
    mem_length_in   = len;
    addr_in         = addr;
    write_data_in   = wd;
    if (is_load) begin
      exp_q.push_back(exp_ld);
      n_loads++;
    end
    #1;
    check("idle_stall", {31'd0, stall}, 32'd1);
    check("idle_req", {31'd0, dmem_req}, 32'd0);
    @(negedge clk);
    check("req_req", {31'd0, dmem_req}, 32'd1);
    check("req_we", {31'd0, dmem_we}, {31'd0, wr});
    check("req_addr", dmem_addr, exp_addr);
    check("req_be", {28'd0, dmem_be}, {28'd0, exp_be});
    if (!is_load) check("req_wdata", dmem_wdata, exp_wdata);
    for (int i = 0; i < gnt_dly; i++) begin
      if (is_load) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = ~rdata;
      end
      @(negedge clk);
      check("wait_req", {31'd0, dmem_req}, 32'd1);
      check("wait_addr", dmem_addr, exp_addr);
      check("wait_stall", {31'd0, stall}, 32'd1);
    end
    dmem_rvalid = 1'b0;
    dmem_gnt    = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    if (is_load) begin
      check("resp_req", {31'd0, dmem_req}, 32'd0);
      check("resp_stall", {31'd0, stall}, 32'd1);
      for (int i = 0; i < rv_dly; i++) begin
        @(negedge clk);
        check("resp_wait_stall", {31'd0, stall}, 32'd1);
      end
      dmem_rvalid = 1'b1;
      dmem_rdata  = rdata;
      @(negedge clk);
      dmem_rvalid = 1'b0;
      dmem_rdata  = 32'h0;
    end
    check("done_stall", {31'd0, stall}, 32'd0);
    check("done_load_valid", {31'd0, load_valid}, {31'd0, is_load});
    @(negedge clk);
    clear_inputs();
    #1;
    check("post_stall", {31'd0, stall}, 32'd0);
    check("post_req", {31'd0, dmem_req}, 32'd0);
    check("post_load_valid", {31'd0, load_valid}, 32'd0);
  endtask

  initial begin
    clear_inputs();
    rst         = 1'b1;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", {31'd0, dmem_req}, 32'd0);
    check("rst_we", {31'd0, dmem_we}, 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_be", {28'd0, dmem_be}, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_load_valid", {31'd0, load_valid}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // signed byte load, top lane
    access(1'b1, 1'b0, 1'b1, 2'b00, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 0,
           32'h0000_1000, 4'b1000, 32'h0, 32'hFFFF_FF80);
    // halfword store with delayed grant
    access(1'b0, 1'b1, 1'b0, 2'b01, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 3, 0,
           32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    // unsigned halfword load; rvalid during REQ must be ignored
    access(1'b1, 1'b0, 1'b0, 2'b01, 32'h0000_0002, 32'h0, 32'hF00D_0000, 1, 0,
           32'h0000_0000, 4'b1100, 32'h0, 32'h0000_F00D);
    // signed halfword load, low lane
    access(1'b1, 1'b0, 1'b1, 2'b01, 32'h0000_4000, 32'h0, 32'h0000_8001, 0, 1,
           32'h0000_4000, 4'b0011, 32'h0, 32'hFFFF_8001);
    // unsigned byte load, lane 1
    access(1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_5001, 32'h0, 32'h0000_AB00, 2, 0,
           32'h0000_5000, 4'b0010, 32'h0, 32'h0000_00AB);
    // length 11 behaves as word
    access(1'b1, 1'b0, 1'b1, 2'b11, 32'h0000_0008, 32'h0, 32'h8765_4321, 0, 0,
           32'h0000_0008, 4'b1111, 32'h0, 32'h8765_4321);
    // read and write both set: byte store
    access(1'b1, 1'b1, 1'b0, 2'b00, 32'h0000_6002, 32'h0000_005A, 32'h0, 0, 0,
           32'h0000_6000, 4'b0100, 32'h5A5A_5A5A, 32'h0);
    // word store
    access(1'b0, 1'b1, 1'b0, 2'b10, 32'h0000_7000, 32'h1234_5678, 32'h0, 1, 0,
           32'h0000_7000, 4'b1111, 32'h1234_5678, 32'h0);

`ifdef MEM_MISALIGN_TRAP_EN
    // misaligned word load traps without a bus request
    mem_read_in   = 1'b1;
    mem_length_in = 2'b10;
    addr_in       = 32'h0000_1001;
    #1;
    check("mis_idle_stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    check("mis_req", {31'd0, dmem_req}, 32'd0);
    check("mis_flag", {31'd0, misalign}, 32'd1);
    check("mis_stall", {31'd0, stall}, 32'd0);
    check("mis_load_valid", {31'd0, load_valid}, 32'd0);
    check("mis_load_data", load_data, 32'd0);
    @(negedge clk);
    clear_inputs();
    #1;
    check("mis_flag_clear", {31'd0, misalign}, 32'd0);
    check("mis_post_req", {31'd0, dmem_req}, 32'd0);
`else
    // misaligned word load is silently aligned
    access(1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_1001, 32'h0, 32'hCAFE_BABE, 0, 2,
           32'h0000_1000, 4'b1111, 32'h0, 32'hCAFE_BABE);
`endif

    // reset while waiting in RESP; late rvalid must be discarded
    mem_read_in   = 1'b1;
    mem_length_in = 2'b10;
    addr_in       = 32'h0000_3000;
    @(negedge clk);
    check("rr_req", {31'd0, dmem_req}, 32'd1);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    check("rr_resp_stall", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hDEAD_BEEF;
    #1;
    check("rr_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    dmem_rvalid = 1'b0;
    check("rr_load_valid", {31'd0, load_valid}, 32'd0);
    check("rr_load_data", load_data, 32'd0);
    check("rr_dmem_req", {31'd0, dmem_req}, 32'd0);
    check("rr_dmem_we", {31'd0, dmem_we}, 32'd0);
    check("rr_dmem_addr", dmem_addr, 32'd0);
    check("rr_dmem_be", {28'd0, dmem_be}, 32'd0);
    check("rr_dmem_wdata", dmem_wdata, 32'd0);
    @(negedge clk);
    check("rr_load_valid2", {31'd0, load_valid}, 32'd0);

    repeat (2) @(negedge clk);
    check("load_pulse_count", lv_count, n_loads);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
